// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: funct3 codes, FSM encoding
// and request-check helpers.
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    WR,
    RESP,
    FAULT
  } state_t;

  function automatic logic f3_ok(input logic [2:0] f3);
    return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
  endfunction

  function automatic logic misaligned(
    input logic [2:0] f3,
    input logic [1:0] off
  );
    return (f3[1:0] == F3_SH[1:0] && off[0])
        || (f3[1:0] == F3_SW[1:0] && off != 2'b00);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Core request/response and data-memory strobe bundle.
// slave is the LSU view; master is the core + dmem view.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        fault;
  logic        dmem_read_ready;
  logic [31:0] dmem_read_address;
  logic [31:0] dmem_read_data;
  logic        dmem_read_valid;
  logic        dmem_write_ready;
  logic [31:0] dmem_write_address;
  logic [31:0] dmem_write_data;
  logic [3:0]  dmem_write_byte;
  logic        dmem_write_valid;

  modport slave (
    input  req_valid, req_write, req_funct3,
    input  req_addr, req_wdata, req_rd,
    input  dmem_read_data, dmem_read_valid,
    input  dmem_write_valid,
    output req_ready, resp_valid, resp_rdata,
    output resp_rd, fault,
    output dmem_read_ready, dmem_read_address,
    output dmem_write_ready, dmem_write_address,
    output dmem_write_data, dmem_write_byte
  );

  modport master (
    output req_valid, req_write, req_funct3,
    output req_addr, req_wdata, req_rd,
    output dmem_read_data, dmem_read_valid,
    output dmem_write_valid,
    input  req_ready, resp_valid, resp_rdata,
    input  resp_rd, fault,
    input  dmem_read_ready, dmem_read_address,
    input  dmem_write_ready, dmem_write_address,
    input  dmem_write_data, dmem_write_byte
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store byte enables and replicated write data,
// load lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_byte,
  output logic [31:0] st_data,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);
  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    st_byte = 4'b1111;
    st_data = st_wdata;
    unique case (1'b1)
      (st_funct3[1:0] == F3_SB[1:0]): begin
        st_byte = 4'b0001 << st_off;
        st_data = {4{st_wdata[7:0]}};
      end
      (st_funct3[1:0] == F3_SH[1:0]): begin
        st_byte = st_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    b = ld_rdata[{ld_off, 3'b000} +: 8];
    h = ld_rdata[{ld_off[1], 4'b0000} +: 16];
    ld_data = ld_rdata;
    unique case (1'b1)
      (ld_funct3 == F3_LB):  ld_data = {{24{b[7]}}, b};
      (ld_funct3 == F3_LBU): ld_data = {24'h0, b};
      (ld_funct3 == F3_LH):  ld_data = {{16{h[15]}}, h};
      (ld_funct3 == F3_LHU): ld_data = {16'h0, h};
      default: ;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one load/store at a time against a synchronous dmem.
// Bad requests and dmem timeouts answer with a fault pulse instead.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DMEMSIZE   = 131072,
  parameter int RD_TIMEOUT = 15
) (
  input logic  clk,
  input logic  reset,
  lsu_if.slave bus
);
  localparam int AW = $clog2(DMEMSIZE);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(RD_TIMEOUT - 1);

  state_t        state;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          bad;
  logic [3:0]    st_byte;
  logic [31:0]   st_data;
  logic [31:0]   ld_data;

  assign accept = bus.req_valid && bus.req_ready;
  assign bad = !f3_ok(bus.req_funct3)
    || misaligned(bus.req_funct3, bus.req_addr[1:0])
    || (|(bus.req_addr >> AW));

  lsu_align u_align (
    .st_funct3 (bus.req_funct3),
    .st_off    (bus.req_addr[1:0]),
    .st_wdata  (bus.req_wdata),
    .st_byte   (st_byte),
    .st_data   (st_data),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_rdata  (bus.dmem_read_data),
    .ld_data   (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      f3_q                   <= '0;
      off_q                  <= '0;
      rd_q                   <= '0;
      cnt                    <= '0;
      bus.req_ready          <= 1'b1;
      bus.resp_valid         <= 1'b0;
      bus.resp_rdata         <= '0;
      bus.resp_rd            <= '0;
      bus.fault              <= 1'b0;
      bus.dmem_read_ready    <= 1'b0;
      bus.dmem_read_address  <= '0;
      bus.dmem_write_ready   <= 1'b0;
      bus.dmem_write_address <= '0;
      bus.dmem_write_data    <= '0;
      bus.dmem_write_byte    <= '0;
    end else begin
      bus.dmem_read_ready  <= 1'b0;
      bus.dmem_write_ready <= 1'b0;
      bus.resp_valid       <= 1'b0;
      bus.fault            <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          f3_q          <= bus.req_funct3;
          off_q         <= bus.req_addr[1:0];
          rd_q          <= bus.req_rd;
          cnt           <= '0;
          bus.req_ready <= 1'b0;
          if (bad) begin
            state          <= FAULT;
            bus.resp_valid <= 1'b1;
            bus.fault      <= 1'b1;
            bus.resp_rdata <= '0;
            bus.resp_rd    <= '0;
          end else if (bus.req_write) begin
            state                  <= WR;
            bus.dmem_write_ready   <= 1'b1;
            bus.dmem_write_address <= {bus.req_addr[31:2], 2'b00};
            bus.dmem_write_data    <= st_data;
            bus.dmem_write_byte    <= st_byte;
          end else begin
            state                 <= RD;
            bus.dmem_read_ready   <= 1'b1;
            bus.dmem_read_address <= {bus.req_addr[31:2], 2'b00};
          end
        end
        RD: begin
          if (bus.dmem_read_valid) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= ld_data;
            bus.resp_rd    <= rd_q;
          end else if (cnt == LAST) begin
            state          <= FAULT;
            bus.resp_valid <= 1'b1;
            bus.fault      <= 1'b1;
            bus.resp_rdata <= '0;
            bus.resp_rd    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WR: begin
          if (bus.dmem_write_valid) begin
            state          <= RESP;
            bus.resp_valid <= 1'b1;
            bus.resp_rdata <= '0;
            bus.resp_rd    <= '0;
          end else if (cnt == LAST) begin
            state          <= FAULT;
            bus.resp_valid <= 1'b1;
            bus.fault      <= 1'b1;
            bus.resp_rdata <= '0;
            bus.resp_rd    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP, FAULT: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural dmem
// and a shadow memory model for expected load data.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  lsu_if bus ();

  load_store_unit #(
    .DMEMSIZE   (131072),
    .RD_TIMEOUT (15)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        flt;
    int          lat;
    int          t0;
  } exp_t;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          strobes = 0;
  bit          stall_rd = 1'b0;
  logic [31:0] mem [256];
  logic [31:0] shadow [256];
  logic [31:0] last_wa, last_wd, last_ra;
  logic [3:0]  last_wb;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // dmem: write accepted in the strobe cycle, read data one cycle later
  initial begin
    bus.dmem_read_valid  = 1'b0;
    bus.dmem_read_data   = '0;
    bus.dmem_write_valid = 1'b0;
    forever begin
      @(negedge clk);
      bus.dmem_write_valid = 1'b0;
      if (bus.dmem_write_ready) begin
        strobes++;
        last_wa = bus.dmem_write_address;
        last_wd = bus.dmem_write_data;
        last_wb = bus.dmem_write_byte;
        for (int i = 0; i < 4; i++)
          if (last_wb[i])
            mem[last_wa[9:2]][8*i +: 8] = last_wd[8*i +: 8];
        bus.dmem_write_valid = 1'b1;
      end
      if (bus.dmem_read_ready) begin
        strobes++;
        last_ra = bus.dmem_read_address;
        if (!stall_rd) begin
          @(posedge clk); #1;
          bus.dmem_read_data  = mem[last_ra[9:2]];
          bus.dmem_read_valid = 1'b1;
          @(posedge clk); #1;
          bus.dmem_read_valid = 1'b0;
          bus.dmem_read_data  = '0;
        end
      end
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.dmem_read_ready || bus.dmem_write_ready)
        check("strobe_excl",
              32'(bus.dmem_read_ready & bus.dmem_write_ready), 0);
      if (bus.fault)
        check("fault_wo_resp", 32'(bus.resp_valid), 1);
      if (bus.resp_valid) begin
        if (sb_q.size() == 0) begin
          check("resp_unexpected", 32'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", bus.resp_rdata, e.rdata);
          check("resp_rd", 32'(bus.resp_rd), 32'(e.rd));
          check("fault", 32'(bus.fault), 32'(e.flt));
          check("latency", 32'(cyc - e.t0), 32'(e.lat));
        end
      end
    end
  end

  function automatic logic [31:0] ld_model(logic [2:0] f3, logic [31:0] a);
    logic [31:0] w;
    logic [31:0] s;
    w = shadow[a[9:2]];
    s = w >> {a[1:0], 3'b000};
    case (f3)
      F3_LB:   return {{24{s[7]}}, s[7:0]};
      F3_LBU:  return {24'h0, s[7:0]};
      F3_LH:   return {{16{s[15]}}, s[15:0]};
      F3_LHU:  return {16'h0, s[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic sh_store(logic [2:0] f3, logic [31:0] a, logic [31:0] d);
    case (f3[1:0])
      2'b00:   shadow[a[9:2]][{a[1:0], 3'b000} +: 8] = d[7:0];
      2'b01:   shadow[a[9:2]][{a[1], 4'b0000} +: 16] = d[15:0];
      default: shadow[a[9:2]] = d;
    endcase
  endtask

  task automatic op(input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd,
                    input logic [4:0] rd, input logic [31:0] erd,
                    input logic flt, input int lat);
    exp_t e;
    int n;
    n = 0;
    while (!bus.req_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.req_valid  = 1'b1;
    bus.req_write  = wr;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    e.rdata = erd;
    e.rd    = (wr || flt) ? 5'd0 : rd;
    e.flt   = flt;
    e.lat   = lat;
    e.t0    = cyc;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (sb_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb_q.size()), 0);
  endtask

  task automatic chk_reset();
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_fault", 32'(bus.fault), 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_rd", 32'(bus.resp_rd), 0);
    check("rst_rd_strobe", 32'(bus.dmem_read_ready), 0);
    check("rst_wr_strobe", 32'(bus.dmem_write_ready), 0);
    check("rst_rd_addr", bus.dmem_read_address, 0);
    check("rst_wr_addr", bus.dmem_write_address, 0);
    check("rst_wr_data", bus.dmem_write_data, 0);
    check("rst_wr_byte", 32'(bus.dmem_write_byte), 0);
  endtask

  initial begin
    int s0;
    logic [31:0] a, d;
    logic [2:0]  f3;
    int sz;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_rd     = '0;
    for (int i = 0; i < 256; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end
    repeat (3) @(negedge clk);
    chk_reset();
    reset = 1'b0;
    @(negedge clk);

    op(1, F3_SW, 32'h100, 32'hDEADBEEF, 5'd3, 0, 0, 2);
    sh_store(F3_SW, 32'h100, 32'hDEADBEEF);
    check("sw_byte", 32'(last_wb), 32'hF);
    check("sw_addr", last_wa, 32'h100);
    check("sw_data", last_wd, 32'hDEADBEEF);

    op(1, F3_SB, 32'h103, 32'h000000A5, 5'd4, 0, 0, 2);
    sh_store(F3_SB, 32'h103, 32'hA5);
    check("sb_byte", 32'(last_wb), 32'h8);
    check("sb_data", last_wd, 32'hA5A5A5A5);
    check("sb_addr", last_wa, 32'h100);

    op(0, F3_LB, 32'h103, 0, 5'd5, 32'hFFFFFFA5, 0, 3);
    check("lb_addr", last_ra, 32'h100);
    op(0, F3_LBU, 32'h103, 0, 5'd6, 32'h000000A5, 0, 3);

    op(1, F3_SH, 32'h102, 32'h00008001, 5'd4, 0, 0, 2);
    sh_store(F3_SH, 32'h102, 32'h8001);
    check("sh_byte", 32'(last_wb), 32'hC);
    check("sh_data", last_wd, 32'h80018001);
    op(0, F3_LH, 32'h102, 0, 5'd7, 32'hFFFF8001, 0, 3);
    op(0, F3_LHU, 32'h102, 0, 5'd8, 32'h00008001, 0, 3);
    op(0, F3_LW, 32'h100, 0, 5'd9, 32'h8001BEEF, 0, 3);

    s0 = strobes;
    op(0, F3_LW, 32'h101, 0, 5'd1, 0, 1, 1);
    op(0, F3_LH, 32'h103, 0, 5'd2, 0, 1, 1);
    op(0, F3_LW, 32'h00020000, 0, 5'd3, 0, 1, 1);
    op(0, 3'b011, 32'h100, 0, 5'd4, 0, 1, 1);
    op(1, F3_SW, 32'h102, 32'h1234, 5'd5, 0, 1, 1);
    op(1, 3'b111, 32'h100, 32'h1234, 5'd6, 0, 1, 1);
    check("fault_no_strobe", 32'(strobes), 32'(s0));

    stall_rd = 1'b1;
    op(0, F3_LW, 32'h100, 0, 5'd10, 0, 1, 16);
    stall_rd = 1'b0;

    for (int i = 0; i < 30; i++) begin
      sz = $urandom_range(0, 2);
      a  = 32'h200 + 32'($urandom_range(0, 31));
      a  = a & ~((32'd1 << sz) - 32'd1);
      d  = $urandom;
      f3 = 3'(sz);
      if ($urandom_range(0, 1) == 1) begin
        op(1, f3, a, d, 5'(i), 0, 0, 2);
        sh_store(f3, a, d);
        check("mem_word", mem[a[9:2]], shadow[a[9:2]]);
      end else begin
        if (sz < 2 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
        op(0, f3, a, 0, 5'(i), ld_model(f3, a), 0, 3);
      end
    end

    // abandon a load mid-wait; nothing may come back afterwards
    stall_rd = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = F3_LW;
    bus.req_addr   = 32'h100;
    bus.req_rd     = 5'd11;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk_reset();
    @(negedge clk);
    reset = 1'b0;
    stall_rd = 1'b0;
    s0 = strobes;
    repeat (20) @(negedge clk);
    check("post_reset_strobes", 32'(strobes), 32'(s0));
    op(0, F3_LW, 32'h100, 0, 5'd12, 32'h8001BEEF, 0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
